// File: rtl/multiplexer_n_to_1_rr.sv
// Registered N-to-1 valid/ready stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last ports) enabled by defining MUX_PKT_LOCK_EN.
module multiplexer_n_to_1_rr #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
`ifdef MUX_PKT_LOCK_EN
    output logic                      out_last,
`endif
    input  logic                      out_ready
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_next_c;
    logic             ptr_adv_c;

    logic             load_c;
    logic             xfer_c;
    logic             grant_valid_c;
    logic [SEL_W-1:0] grant_idx_c;
    logic [WIDTH-1:0] grant_data_c;
    logic             grant_last_c;

    logic             fix_valid_c;
    logic [SEL_W-1:0] fix_idx_c;
    logic             rr_valid_c;
    logic [SEL_W-1:0] rr_idx_c;

    assign load_c = !out_valid || out_ready;

    // Fixed select: an out-of-range sel never matches any channel.
    always_comb begin : fixed_grant
        fix_valid_c = 1'b0;
        fix_idx_c   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_valid_c = 1'b1;
                fix_idx_c   = SEL_W'(i);
            end
        end
    end

    // Round-robin: first valid at or above ptr, otherwise first valid below ptr.
    always_comb begin : rr_grant
        rr_valid_c = 1'b0;
        rr_idx_c   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!rr_valid_c && in_valid[i] && i >= 32'(ptr_q)) begin
                rr_valid_c = 1'b1;
                rr_idx_c   = SEL_W'(i);
            end
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!rr_valid_c && in_valid[i] && i < 32'(ptr_q)) begin
                rr_valid_c = 1'b1;
                rr_idx_c   = SEL_W'(i);
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

    lock_state_t      lock_state_q;
    lock_state_t      lock_state_next_c;
    logic [SEL_W-1:0] lock_chan_q;
    logic [SEL_W-1:0] lock_chan_next_c;
    logic             lock_valid_c;

    always_comb begin : lock_valid
        lock_valid_c = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (lock_chan_q == SEL_W'(i) && in_valid[i]) begin
                lock_valid_c = 1'b1;
            end
        end
    end
`endif

    // Final grant; an open packet overrides mode, sel and the ptr search.
    always_comb begin : grant_sel
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
`ifdef MUX_PKT_LOCK_EN
        if (lock_state_q == ST_LOCKED) begin
            grant_valid_c = lock_valid_c;
            grant_idx_c   = lock_chan_q;
        end else
`endif
        if (mode) begin
            grant_valid_c = rr_valid_c;
            grant_idx_c   = rr_idx_c;
        end else begin
            grant_valid_c = fix_valid_c;
            grant_idx_c   = fix_idx_c;
        end
    end

    always_comb begin : grant_payload
        grant_data_c = '0;
        grant_last_c = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_idx_c == SEL_W'(i)) begin
                grant_data_c = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_PKT_LOCK_EN
                grant_last_c = in_last[i];
`endif
            end
        end
    end

    // in_ready is held low while reset is asserted even though load_c is then 1.
    assign xfer_c = rst_n && load_c && grant_valid_c;

    always_comb begin : ready_decode
        in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            in_ready[i] = xfer_c && (grant_idx_c == SEL_W'(i));
        end
    end

    assign ptr_adv_c  = xfer_c && grant_last_c;
    assign ptr_next_c = (grant_idx_c == SEL_W'(CHANNELS - 1)) ? '0
                                                               : grant_idx_c + SEL_W'(1);

`ifdef MUX_PKT_LOCK_EN
    always_comb begin : lock_next
        lock_state_next_c = lock_state_q;
        lock_chan_next_c  = lock_chan_q;
        if (xfer_c) begin
            if (grant_last_c) begin
                lock_state_next_c = ST_OPEN;
            end else begin
                lock_state_next_c = ST_LOCKED;
                lock_chan_next_c  = grant_idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : lock_reg
        if (!rst_n) begin
            lock_state_q <= ST_OPEN;
            lock_chan_q  <= '0;
        end else begin
            lock_state_q <= lock_state_next_c;
            lock_chan_q  <= lock_chan_next_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : last_reg
        if (!rst_n) begin
            out_last <= 1'b0;
        end else if (xfer_c) begin
            out_last <= grant_last_c;
        end
    end
`endif

    // Output register: loads a new beat, drains to empty, or holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin : out_reg
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_c) begin
            out_valid <= grant_valid_c;
            if (grant_valid_c) begin
                out_data <= grant_data_c;
                out_chan <= grant_idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ptr_reg
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (ptr_adv_c) begin
            ptr_q <= ptr_next_c;
        end
    end

endmodule

// File: doc/multiplexer_n_to_1_rr.md
# multiplexer_n_to_1_rr

Parametrised, registered N-to-1 stream multiplexer with a valid/ready handshake on every input channel and on the output. It is the successor to the combinational 4-to-1 mux: channel count and data width are generic. Selection is either fixed by a select input or by round-robin arbitration among requesting channels. It sits between several producer streams and a single downstream consumer, and provides a one-entry output register that breaks the timing path.

## Interface
Parameters:
- WIDTH, 8, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), width of select and channel-index fields

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset, release synchronous to clk
- mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready, at most one bit high
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts beat

## Operation
- load = !out_valid || out_ready. The output register may accept a new beat only when load=1.
- Grant, mode=0: channel sel is granted if sel < CHANNELS and in_valid[sel]=1. If sel ≥ CHANNELS, no channel is granted.
- Grant, mode=1: the first i with in_valid[i]=1, searching from ptr upward and wrapping CHANNELS-1→0.
- in_ready[g] = load && grant_valid. All other in_ready bits are 0. in_ready is combinational from in_valid, sel, mode, ptr, out_valid and out_ready.
- On transfer (in_valid[g] && in_ready[g]):
  - out_data ← in_data[g], out_chan ← g, out_valid ← 1
  - ptr ← (g == CHANNELS-1) ? 0 : g+1
- ptr also advances on transfers in mode=0, so round-robin resumes fairly after a mode switch.
- load=1 with no grant: out_valid ← 0. out_data and out_chan hold their previous values.
- out_valid=1 with out_ready=0: out_data, out_chan and out_valid are held stable. No input is accepted.
- A mode or sel change takes effect on the same cycle's arbitration. It never alters a beat already in the output register.
- Reset (asynchronous assert, any time including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0, ptr=0, lock state cleared
  - in_ready=0 for all channels while rst_n=0
  - any in-flight beat is dropped

## Timing
- Latency: input transfer at edge k → out_valid=1 with that data after edge k.
- Throughput: one beat per cycle when out_ready is held at 1.
- Simultaneous out_ready=1 and new grant in the same cycle: the old beat leaves and the new beat loads on the same edge. There is no bubble.
- Round-robin fairness: with all channels valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,…
- No combinational path from in_data to out_data.

## Configuration
- Macro: MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, CHANNELS) and out_last (output, 1, registered alongside out_data, reset 0).
  - After a transfer with in_last[g]=0, the grant is locked to g. mode, sel and ptr search are ignored until a beat from g with in_last[g]=1 transfers.
  - ptr advances only on that last beat.
  - A lock channel dropping in_valid stalls the output; other channels remain un-granted.
- Undefined: the in_last and out_last ports are absent. Every beat is arbitrated independently.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately. After release, first round-robin grant goes to channel 0.
- Fixed select: mode=0, sel=2, all valid, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100, next cycle out_data=8'hA5, out_chan=2. With sel=3 and in_valid[3]=0 → in_ready=0 and out_valid drops to 0.
- Round-robin: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_ready=0 while out_valid=1 for 3 cycles → in_ready=0 and out_data/out_chan stable. Raising out_ready with channel 1 valid → out_data updates to channel 1 on the next edge with no bubble.
- Mode switch: transfer from channel 2 in mode=0, then mode=1 with all valid → next grant is channel 3.
- With MUX_PKT_LOCK_EN: channel 0 sends a 3-beat packet (in_last on beat 3) while channel 1 is valid throughout → out_chan=0,0,0 then 1, with out_last=1 on the third beat only.
